// File: rtl/lcd_pkg.sv
// Shared constants, FSM/instruction enums and address-counter helpers for the
// HD44780 bus-side responder.
package lcd_pkg;

    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam int         LINE_LEN   = 16;
    localparam int         DDRAM_LEN  = 2 * LINE_LEN;
    localparam logic [7:0] SPACE      = 8'h20;

    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPLAY = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNC    = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    localparam int ERR_UNSUPPORTED = 0;
    localparam int ERR_BAD_ADDR    = 1;
    localparam int ERR_BUSY_WRITE  = 2;
    localparam int ERR_EN_SHORT    = 3;

    typedef enum logic [2:0] {
        ST_INIT_FILL, ST_IDLE, ST_EXEC, ST_FILL, ST_BUSY
    } state_e;

    typedef enum logic [3:0] {
        I_NONE, I_CLEAR, I_HOME, I_ENTRY, I_DISPLAY, I_SHIFT, I_FUNC, I_CGRAM, I_DDRAM
    } instr_e;

    // The instruction is selected by the most significant set bit.
    function automatic instr_e decode_instr(input logic [7:0] d);
        if ((d & OP_DDRAM)   != 8'h00) return I_DDRAM;
        if ((d & OP_CGRAM)   != 8'h00) return I_CGRAM;
        if ((d & OP_FUNC)    != 8'h00) return I_FUNC;
        if ((d & OP_SHIFT)   != 8'h00) return I_SHIFT;
        if ((d & OP_DISPLAY) != 8'h00) return I_DISPLAY;
        if ((d & OP_ENTRY)   != 8'h00) return I_ENTRY;
        if ((d & OP_HOME)    != 8'h00) return I_HOME;
        if ((d & OP_CLEAR)   != 8'h00) return I_CLEAR;
        return I_NONE;
    endfunction

    function automatic logic ac_valid(input logic [6:0] ac);
        int off1;
        int off2;
        off1 = int'(ac) - int'(LINE1_BASE);
        off2 = int'(ac) - int'(LINE2_BASE);
        return (off1 >= 0 && off1 < LINE_LEN) || (off2 >= 0 && off2 < LINE_LEN);
    endfunction

    function automatic logic [4:0] ac_idx(input logic [6:0] ac);
        if (ac >= LINE2_BASE) return 5'(int'(ac) - int'(LINE2_BASE) + LINE_LEN);
        return 5'(int'(ac) - int'(LINE1_BASE));
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == LINE1_BASE + 7'(LINE_LEN - 1)) return LINE2_BASE;
            if (ac == LINE2_BASE + 7'(LINE_LEN - 1)) return LINE1_BASE;
            return ac + 7'd1;
        end
        if (ac == LINE1_BASE) return LINE2_BASE + 7'(LINE_LEN - 1);
        if (ac == LINE2_BASE) return LINE1_BASE + 7'(LINE_LEN - 1);
        return ac - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_hd44780_responder_if.sv
// LCD parallel bus between the lab controller (master) and the display
// responder (slave).
interface lcd_hd44780_responder_if;
    logic       lcd_on;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;

    modport master (
        output lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data_in,
        input  lcd_data_out, lcd_data_oe
    );

    modport slave (
        input  lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data_in,
        output lcd_data_out, lcd_data_oe
    );
endinterface

// File: rtl/lcd_ddram.sv
// 32x8 display data RAM: one synchronous write port, asynchronous reads for
// the bus and for the debug/readback port.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       we_i,
    input  logic [4:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [4:0] raddr_i,
    output logic [7:0] rdata_o,
    input  logic [4:0] dbg_addr_i,
    output logic [7:0] dbg_data_o
);
    logic [7:0] mem [DDRAM_LEN];

    // NOTE: storage has no reset; the fill pass after reset writes spaces through this port.
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o    = mem[raddr_i];
    assign dbg_data_o = mem[dbg_addr_i];
endmodule

// File: rtl/lcd_hd44780_responder.sv
// Display end of the HD44780 8-bit bus: strobe qualification, instruction
// decode, DDRAM/address counter, busy timing and bus reads.
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int MIN_EN_HIGH_CYC = 13,
    parameter int BUSY_SHORT_CYC  = 1112,
    parameter int BUSY_LONG_CYC   = 45556
) (
    input  logic                     clk,
    input  logic                     rst,
    lcd_hd44780_responder_if.slave   bus,
    output logic                     busy,
    output logic                     disp_on,
    input  logic [4:0]               dbg_addr,
    output logic [7:0]               dbg_char,
    output logic [15:0]              cmd_count,
    output logic [3:0]               err
);
    localparam int                HCNT_W   = $clog2(MIN_EN_HIGH_CYC + 1);
    localparam logic [HCNT_W-1:0] HCNT_MIN = HCNT_W'(MIN_EN_HIGH_CYC);
    localparam logic [15:0]       SHORT_LD = 16'(BUSY_SHORT_CYC);
    localparam logic [15:0]       LONG_LD  = 16'(BUSY_LONG_CYC);

    state_e            state_q, state_d;
    logic [4:0]        fill_idx_q, fill_idx_d;
    logic [15:0]       busy_cnt_q, busy_cnt_d;
    logic [6:0]        ac_q, ac_d;
    logic              id_q, id_d;
    logic              disp_on_q, disp_on_d;
    logic [15:0]       cmd_count_q, cmd_count_d;
    logic [3:0]        err_q, err_d;
    logic              oe_q, oe_d;
    logic [7:0]        dout_q, dout_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              en_q, rs_q, rw_q;
    logic [7:0]        data_q;

    logic       rise, fall;
    logic       mem_we;
    logic [4:0] mem_waddr;
    logic [7:0] mem_wdata, rd_data;

    lcd_ddram u_ddram (
        .clk        (clk),
        .we_i       (mem_we),
        .waddr_i    (mem_waddr),
        .wdata_i    (mem_wdata),
        .raddr_i    (ac_idx(ac_q)),
        .rdata_o    (rd_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_char)
    );

    assign rise = bus.lcd_en & ~en_q;
    assign fall = ~bus.lcd_en & en_q;

    // NOTE: every _d takes its _q value first so no branch can leave one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        fill_idx_d  = fill_idx_q;
        busy_cnt_d  = (busy_cnt_q != 16'd0) ? busy_cnt_q - 16'd1 : busy_cnt_q;
        ac_d        = ac_q;
        id_d        = id_q;
        disp_on_d   = disp_on_q;
        cmd_count_d = cmd_count_q;
        err_d       = err_q;
        oe_d        = oe_q;
        dout_d      = dout_q;
        hcnt_d      = hcnt_q;
        mem_we      = 1'b0;
        mem_waddr   = fill_idx_q;
        mem_wdata   = SPACE;

        if (rise)                                 hcnt_d = HCNT_W'(1);
        else if (bus.lcd_en && hcnt_q < HCNT_MIN) hcnt_d = hcnt_q + HCNT_W'(1);

        if (bus.lcd_en && bus.lcd_rw)
            dout_d = bus.lcd_rs ? (ac_valid(ac_q) ? rd_data : 8'h00) : {busy, ac_q};
        if (rise && bus.lcd_rw) oe_d = 1'b1;
        else if (fall)          oe_d = 1'b0;

        if (fall && bus.lcd_on) begin
            if (hcnt_q < HCNT_MIN) begin
                err_d[ERR_EN_SHORT] = 1'b1;
            end else if (!rw_q) begin
                if (busy) begin
                    err_d[ERR_BUSY_WRITE] = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                    if (cmd_count_q != 16'hFFFF) cmd_count_d = cmd_count_q + 16'd1;
                end
            end else if (rs_q) begin
                ac_d = ac_step(ac_q, id_q);
            end
        end

        unique case (state_q)
            ST_INIT_FILL, ST_FILL: begin
                mem_we     = 1'b1;
                fill_idx_d = fill_idx_q + 5'd1;
                if (fill_idx_q == 5'(DDRAM_LEN - 1)) begin
                    state_d = (state_q == ST_FILL) ? ST_BUSY : ST_IDLE;
                    if (state_q == ST_FILL) busy_cnt_d = LONG_LD;
                end
            end
            ST_EXEC: begin
                state_d    = ST_BUSY;
                busy_cnt_d = SHORT_LD;
                if (rs_q) begin
                    if (ac_valid(ac_q)) begin
                        mem_we    = 1'b1;
                        mem_waddr = ac_idx(ac_q);
                        mem_wdata = data_q;
                    end else begin
                        err_d[ERR_BAD_ADDR] = 1'b1;
                    end
                    ac_d = ac_step(ac_q, id_q);
                end else begin
                    unique case (decode_instr(data_q))
                        I_CLEAR: begin
                            state_d    = ST_FILL;
                            fill_idx_d = 5'd0;
                            busy_cnt_d = 16'd0;
                            ac_d       = LINE1_BASE;
                            id_d       = 1'b1;
                        end
                        I_HOME: begin
                            ac_d       = LINE1_BASE;
                            busy_cnt_d = LONG_LD;
                        end
                        I_ENTRY: begin
                            id_d = data_q[1];
                            if (data_q[0]) err_d[ERR_UNSUPPORTED] = 1'b1;
                        end
                        I_DISPLAY: disp_on_d = data_q[2];
                        I_SHIFT: begin
                            if (data_q[3]) err_d[ERR_UNSUPPORTED] = 1'b1;
                            else           ac_d = ac_step(ac_q, data_q[2]);
                        end
                        I_FUNC:  if (!data_q[4]) err_d[ERR_UNSUPPORTED] = 1'b1;
                        I_CGRAM: err_d[ERR_UNSUPPORTED] = 1'b1;
                        I_DDRAM: begin
                            ac_d = data_q[6:0];
                            if (!ac_valid(data_q[6:0])) err_d[ERR_BAD_ADDR] = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_BUSY: if (busy_cnt_q <= 16'd1) state_d = ST_IDLE;
            default: ;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT_FILL;
            fill_idx_q  <= 5'd0;
            busy_cnt_q  <= 16'd0;
            ac_q        <= LINE1_BASE;
            id_q        <= 1'b1;
            disp_on_q   <= 1'b0;
            cmd_count_q <= 16'd0;
            err_q       <= 4'd0;
            oe_q        <= 1'b0;
            dout_q      <= 8'h00;
            hcnt_q      <= '0;
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            fill_idx_q  <= fill_idx_d;
            busy_cnt_q  <= busy_cnt_d;
            ac_q        <= ac_d;
            id_q        <= id_d;
            disp_on_q   <= disp_on_d;
            cmd_count_q <= cmd_count_d;
            err_q       <= err_d;
            oe_q        <= oe_d;
            dout_q      <= dout_d;
            hcnt_q      <= hcnt_d;
            en_q        <= bus.lcd_en;
            // Bus fields track the last EN-high cycle so they are stable at the fall.
            if (bus.lcd_en) begin
                rs_q   <= bus.lcd_rs;
                rw_q   <= bus.lcd_rw;
                data_q <= bus.lcd_data_in;
            end
        end
    end

    assign busy             = (busy_cnt_q != 16'd0) || (state_q != ST_IDLE);
    assign disp_on          = disp_on_q;
    assign cmd_count        = cmd_count_q;
    assign err              = err_q;
    assign bus.lcd_data_out = dout_q;
    assign bus.lcd_data_oe  = oe_q & bus.lcd_on;
endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Scoreboarded bench for the HD44780 responder: reads push their expected
// byte, a negedge monitor pops and compares when the read cycle ends.
module tb_lcd_hd44780_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy, disp_on;
    logic [4:0]  dbg_addr = 5'd0;
    logic [7:0]  dbg_char;
    logic [15:0] cmd_count;
    logic [3:0]  err;

    int total = 0;
    int bad   = 0;

    string       tag_q[$];
    logic [15:0] exp_q[$];

    int         busy_run = 0, last_busy_run = 0;
    int         oe_run = 0, last_oe_run = 0;
    logic [7:0] rd_val = 8'h00;

    lcd_hd44780_responder_if bus_if ();

    lcd_hd44780_responder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .busy      (busy),
        .disp_on   (disp_on),
        .dbg_addr  (dbg_addr),
        .dbg_char  (dbg_char),
        .cmd_count (cmd_count),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("busy_timeout", 16'(busy), 16'h0000);
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic rs, input logic rw, input logic [7:0] d, input int hi);
        @(posedge clk);
        #1;
        bus_if.lcd_rs      = rs;
        bus_if.lcd_rw      = rw;
        bus_if.lcd_data_in = d;
        bus_if.lcd_en      = 1'b1;
        repeat (hi) @(posedge clk);
        #1;
        bus_if.lcd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic rs, input logic [7:0] d);
        wait_idle();
        strobe(rs, 1'b0, d, 20);
    endtask

    task automatic read(input logic rs, input string tag, input logic [7:0] exp);
        wait_idle();
        tag_q.push_back(tag);
        exp_q.push_back({8'h00, exp});
        strobe(rs, 1'b1, 8'h00, 20);
    endtask

    // Monitor: busy/oe run lengths and scoreboard pop at the end of each read.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_run = 0;
                oe_run   = 0;
            end else begin
                if (busy) busy_run++;
                else if (busy_run != 0) begin
                    last_busy_run = busy_run;
                    busy_run      = 0;
                end
                if (bus_if.lcd_data_oe) begin
                    oe_run++;
                    rd_val = bus_if.lcd_data_out;
                end else if (oe_run != 0) begin
                    last_oe_run = oe_run;
                    oe_run      = 0;
                    if (exp_q.size() == 0) check("rd_unexpected", 16'h0001, 16'h0000);
                    else check(tag_q.pop_front(), {8'h00, rd_val}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bus_if.lcd_on      = 1'b1;
        bus_if.lcd_en      = 1'b0;
        bus_if.lcd_rs      = 1'b0;
        bus_if.lcd_rw      = 1'b0;
        bus_if.lcd_data_in = 8'h00;

        // Reset and power-up fill
        #20;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_busy", 16'(busy), 16'h0001);
        check("rst_err", 16'(err), 16'h0000);
        check("rst_cmd_count", cmd_count, 16'h0000);
        check("rst_disp_on", 16'(disp_on), 16'h0000);
        check("rst_oe", 16'(bus_if.lcd_data_oe), 16'h0000);
        check("rst_data_out", 16'(bus_if.lcd_data_out), 16'h0000);
        wait_idle();
        check("init_fill_busy_len", 16'(last_busy_run), 16'd32);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check($sformatf("init_fill[%0d]", i), 16'(dbg_char), 16'h0020);
        end

        // Initialisation sequence ending in clear
        write(1'b0, 8'h38);
        write(1'b0, 8'h0C);
        write(1'b0, 8'h06);
        write(1'b0, 8'h01);
        wait_idle();
        check("disp_on", 16'(disp_on), 16'h0001);
        check("cmd_count_init", cmd_count, 16'd4);
        check("clear_busy_len_ok",
              16'((last_busy_run >= 32 + 45556) && (last_busy_run <= 32 + 45556 + 4)), 16'h0001);
        check("err_after_init", 16'(err), 16'h0000);

        // Line wrap on data write, then busy-flag/AC read
        write(1'b0, 8'h8F);
        write(1'b1, 8'h41);
        write(1'b1, 8'h42);
        dbg_addr = 5'd15;
        #1 check("ddram15", 16'(dbg_char), 16'h0041);
        dbg_addr = 5'd16;
        #1 check("ddram16", 16'(dbg_char), 16'h0042);
        read(1'b0, "rd_ac_after_wrap", 8'h41);

        // Write while busy is rejected
        write(1'b1, 8'h58);
        strobe(1'b1, 1'b0, 8'h59, 20);
        check("err_busy_write", 16'(err), 16'h0004);
        check("cmd_count_busy", cmd_count, 16'd8);
        dbg_addr = 5'd17;
        #1 check("ddram17", 16'(dbg_char), 16'h0058);
        dbg_addr = 5'd18;
        #1 check("ddram18_untouched", 16'(dbg_char), 16'h0020);

        // Short EN pulse is discarded
        wait_idle();
        strobe(1'b1, 1'b0, 8'h31, 5);
        check("err_en_short", 16'(err), 16'h000C);
        check("cmd_count_short", cmd_count, 16'd8);
        #1 check("ddram18_after_short", 16'(dbg_char), 16'h0020);

        // Data read from line 2 with AC step, oe window
        write(1'b0, 8'hC0);
        read(1'b1, "rd_ddram16", 8'h42);
        check("oe_len", 16'(last_oe_run), 16'd20);
        check("oe_low_after", 16'(bus_if.lcd_data_oe), 16'h0000);
        read(1'b0, "rd_ac_after_read", 8'h41);

        // Panel off: strobes ignored
        wait_idle();
        bus_if.lcd_on = 1'b0;
        strobe(1'b1, 1'b0, 8'h33, 20);
        bus_if.lcd_on = 1'b1;
        check("cmd_count_panel_off", cmd_count, 16'd9);
        dbg_addr = 5'd17;
        #1 check("ddram17_panel_off", 16'(dbg_char), 16'h0058);

        // Out-of-range DDRAM address and CGRAM access
        write(1'b0, 8'h90);
        wait_idle();
        check("err_bad_addr", 16'(err), 16'h000E);
        write(1'b0, 8'h40);
        wait_idle();
        check("err_unsupported", 16'(err), 16'h000F);
        check("cmd_count_final", cmd_count, 16'd11);
        check("scoreboard_empty", 16'(exp_q.size()), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
